// File: rtl/ic_check_pkg.sv
// ic_check_pkg: shared state encoding, sweep sizes and the saturating arithmetic-shift reference
package ic_check_pkg;
  localparam int W_DEF = 4;
  localparam int NX = 1 << W_DEF;
  localparam int NVEC = 1 << (2 * W_DEF);
  typedef enum logic [2:0] {IDLE, SEARCH, WAIT, COMPARE, NEXT, DONE} state_t;
  // Bits at or above w are zero; shifts of w or more fill with the sign bit.
  function automatic logic [31:0] ashr_sat(input logic [31:0] x, input logic [31:0] s, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < w) r[i] = (s < 32'(w - i)) ? x[i + int'(s)] : x[w - 1];
    return r;
  endfunction
endpackage

// File: rtl/ic_bvashr_exhaustive_checker_ref.sv
// bvashr_ref_unit: combinational test of whether ashr_sat(x, s) equals t
module bvashr_ref_unit
  import ic_check_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  output logic         eq
);
  logic [31:0] r;
  assign r = ashr_sat(32'(x), 32'(s), W);
  assign eq = r == 32'(t);
endmodule

// File: rtl/ic_bvashr_exhaustive_checker.sv
// ic_bvashr_exhaustive_checker: sweeps all (s,t), brute-forces the bvashr invertibility
// condition per vector and compares it with the circuit under test's output
module ic_bvashr_exhaustive_checker
  import ic_check_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int DUT_LAT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [2*W-1:0] vec_out,
  input  logic           dut_y,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   mismatch_count,
  output logic           first_fail_valid,
  output logic [2*W-1:0] first_fail_vec
);
  localparam int SW = $clog2(DUT_LAT + 2);
  localparam logic [SW-1:0] LAT = SW'(DUT_LAT);
  state_t state_q, state_d;
  logic [2*W-1:0] vec_q, vec_d, ffvec_q, ffvec_d;
  logic [W-1:0] x_q, x_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [2*W:0] mm_q, mm_d;
  logic hit_q, hit_d, pass_q, pass_d, ffv_q, ffv_d, eq;
  bvashr_ref_unit #(.W(W)) u_ref (.x(x_q), .s(vec_q[W-1:0]), .t(vec_q[2*W-1:W]), .eq(eq));
  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    x_d = x_q;
    hit_d = hit_q;
    pass_d = pass_q;
    mm_d = mm_q;
    ffv_d = ffv_q;
    ffvec_d = ffvec_q;
    settle_d = (settle_q == LAT) ? settle_q : settle_q + SW'(1);
    case (state_q)
      IDLE: if (start) begin
        state_d = SEARCH;
        vec_d = '0;
        x_d = '0;
        settle_d = '0;
        hit_d = 1'b0;
        pass_d = 1'b0;
        mm_d = '0;
        ffv_d = 1'b0;
        ffvec_d = '0;
      end
      SEARCH: if (eq || &x_q) begin
        hit_d = eq;
        state_d = WAIT;
      end else x_d = x_q + W'(1);
      WAIT: if (settle_q == LAT) state_d = COMPARE;
      COMPARE: begin
        state_d = NEXT;
        if (dut_y != hit_q) begin
          mm_d = mm_q + (2*W+1)'(1);
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffvec_d = vec_q;
          end
        end
      end
      NEXT: if (&vec_q) begin
        state_d = DONE;
        pass_d = mm_q == '0;
      end else begin
        state_d = SEARCH;
        vec_d = vec_q + (2*W)'(1);
        x_d = '0;
        settle_d = '0;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q <= '0;
      x_q <= '0;
      settle_q <= '0;
      hit_q <= 1'b0;
      pass_q <= 1'b0;
      mm_q <= '0;
      ffv_q <= 1'b0;
      ffvec_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
      x_q <= x_d;
      settle_q <= settle_d;
      hit_q <= hit_d;
      pass_q <= pass_d;
      mm_q <= mm_d;
      ffv_q <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end
  assign vec_out = vec_q;
  assign busy = state_q inside {SEARCH, WAIT, COMPARE, NEXT};
  assign done = state_q == DONE;
  assign pass = pass_q;
  assign mismatch_count = mm_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec = ffvec_q;
endmodule

// File: tb/tb_ic_bvashr_exhaustive_checker.sv
// tb_ic_bvashr_exhaustive_checker: drives modelled circuits-under-test into two checker instances
// (latency 0 and 3) and checks results against a brute-force IC and timeline model
module tb_ic_bvashr_exhaustive_checker;
  import ic_check_pkg::*;
  logic clk = 1'b0, rst = 1'b1, start0 = 1'b0, start1 = 1'b0, y0, y1;
  logic [7:0] vec0, vec1, ffvec0, ffvec1;
  logic busy0, busy1, done0, done1, pass0, pass1, ffv0, ffv1;
  logic [8:0] mm0, mm1;
  logic [7:0] dl0 = '0, dl1 = '0;
  bit flip [NVEC];
  int mode0 = 0, mode1 = 4;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  ic_bvashr_exhaustive_checker #(.W(4), .DUT_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .vec_out(vec0), .dut_y(y0), .busy(busy0),
    .done(done0), .pass(pass0), .mismatch_count(mm0), .first_fail_valid(ffv0),
    .first_fail_vec(ffvec0));
  ic_bvashr_exhaustive_checker #(.W(4), .DUT_LAT(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .vec_out(vec1), .dut_y(y1), .busy(busy1),
    .done(done1), .pass(pass1), .mismatch_count(mm1), .first_fail_valid(ffv1),
    .first_fail_vec(ffvec1));

  // Index+1 of the smallest x with (x >>> s) == t, 0 when none exists.
  function automatic int first_x(input logic [7:0] v);
    logic signed [3:0] xs, r;
    for (int x = 0; x < NX; x++) begin
      xs = 4'(x);
      r = xs >>> v[3:0];
      if (r == v[7:4]) return x + 1;
    end
    return 0;
  endfunction

  function automatic logic model_y(input int mode, input logic [7:0] v);
    logic ic;
    ic = first_x(v) != 0;
    return mode == 1 ? 1'b0 : mode == 2 ? 1'b1 : mode == 3 ? ic ^ flip[v] : ic;
  endfunction

  always_comb y0 = mode0 == 4 ? dl0[2] : mode0 == 5 ? dl0[5] : model_y(mode0, vec0);
  always_comb y1 = mode1 == 4 ? dl1[2] : model_y(mode1, vec1);
  always @(posedge clk) begin
    dl0 <= {dl0[6:0], first_x(vec0) != 0};
    dl1 <= {dl1[6:0], first_x(vec1) != 0};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected results for a latency-0 sweep, using a per-cycle IC history of vec_out for delayed models.
  task automatic exp_calc(input int mode, output int emm, output bit effv, output int effvec,
                          output int ecyc);
    bit q[$];
    int f, k, cmp;
    logic y, ic;
    emm = 0; effv = 0; effvec = 0; ecyc = 0;
    repeat (8) q.push_back(1'b1);
    for (int v = 0; v < NVEC; v++) begin
      f = first_x(8'(v));
      k = f != 0 ? f : NX;
      ic = f != 0;
      cmp = q.size() + k + 1;
      repeat (k + 3) q.push_back(ic);
      y = mode == 4 ? q[cmp - 3] : mode == 5 ? q[cmp - 6] : model_y(mode, 8'(v));
      ecyc += k + 3;
      if (y != ic) begin
        emm++;
        if (!effv) begin
          effv = 1;
          effvec = v;
        end
      end
    end
  endtask

  task automatic sweep(input int inst, input bit mid, output int cyc, output bit to);
    cyc = 0;
    to = 1;
    @(negedge clk);
    if (inst == 1) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    for (int n = 0; n < 30000; n++) begin
      if (inst == 1 ? done1 : done0) begin
        to = 0;
        break;
      end
      if (inst == 1 ? busy1 : busy0) cyc++;
      if (mid) start0 = n == 100;
      @(negedge clk);
    end
    start0 = 1'b0;
  endtask

  task automatic run0(input int mode, input bit mid, input string tag);
    int cyc, emm, effvec, ecyc;
    bit to, effv;
    mode0 = mode;
    exp_calc(mode, emm, effv, effvec, ecyc);
    sweep(0, mid, cyc, to);
    chk({tag, "_timeout"}, 32'(to), 0);
    chk({tag, "_pass"}, 32'(pass0), 32'(emm == 0));
    chk({tag, "_mm"}, 32'(mm0), 32'(emm));
    chk({tag, "_ffv"}, 32'(ffv0), 32'(effv));
    chk({tag, "_ffvec"}, 32'(ffvec0), 32'(effvec));
    chk({tag, "_cycles"}, 32'(cyc), 32'(ecyc));
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk({tag, "_done_pulse"}, 32'(done0), 0);
    chk({tag, "_start_in_done"}, 32'(busy0), 0);
    chk({tag, "_pass_held"}, 32'(pass0), 32'(emm == 0));
    chk({tag, "_mm_held"}, 32'(mm0), 32'(emm));
  endtask

  initial begin
    int cyc;
    bit to;
    #12;
    chk("rst_vec", 32'(vec0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_pass", 32'(pass0), 0);
    chk("rst_mm", 32'(mm0), 0);
    chk("rst_ffv", 32'(ffv0), 0);
    chk("rst_ffvec", 32'(ffvec0), 0);
    @(negedge clk);
    rst = 1'b0;
    run0(0, 1'b1, "golden");
    run0(1, 1'b0, "stuck0");
    run0(2, 1'b0, "stuck1");
    foreach (flip[i]) flip[i] = 1'b0;
    flip[8'hA7] = 1'b1;
    run0(3, 1'b0, "flip_a7");
    for (int r = 0; r < 2; r++) begin
      foreach (flip[i]) flip[i] = $urandom_range(0, 15) == 0;
      run0(3, 1'b0, "flip_rand");
    end
    run0(4, 1'b0, "delay3_lat0");
    run0(5, 1'b0, "delay6_lat0");
    mode1 = 4;
    sweep(1, 1'b0, cyc, to);
    chk("delay3_lat3_timeout", 32'(to), 0);
    chk("delay3_lat3_pass", 32'(pass1), 1);
    chk("delay3_lat3_mm", 32'(mm1), 0);
    chk("delay3_lat3_ffv", 32'(ffv1), 0);
    mode0 = 2;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    to = 1;
    for (int n = 0; n < 30000; n++) begin
      if (vec0 == 8'h40) begin
        to = 0;
        break;
      end
      @(negedge clk);
    end
    chk("midrst_reach_40", 32'(to), 0);
    chk("midrst_mm_before", 32'(mm0 != 0), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_vec", 32'(vec0), 0);
    chk("midrst_busy", 32'(busy0), 0);
    chk("midrst_done", 32'(done0), 0);
    chk("midrst_pass", 32'(pass0), 0);
    chk("midrst_mm", 32'(mm0), 0);
    chk("midrst_ffv", 32'(ffv0), 0);
    chk("midrst_ffvec", 32'(ffvec0), 0);
    @(negedge clk);
    rst = 1'b0;
    run0(0, 1'b0, "after_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ic_bvashr_exhaustive_checker.md
Name: ic_bvashr_exhaustive_checker

Overview:
Sequential harness stage wrapped around a synthesized bvashr invertibility-condition Skolem circuit.
- Upstream role: sweeps every assignment of the circuit's 2W universal inputs (s, t) on vec_out.
- Downstream role: samples the circuit's single output and compares it against a brute-force reference: IC(s,t) = exists x in [0, 2^W) such that (x >>>a s) == t.
- Reports pass/fail, the mismatch count and the first failing vector. Used in on-FPGA or simulation sign-off of generated Skolem netlists.

Parameters:
W, 4, bit width of s, t and x; the circuit under test has 2W inputs (W=4 gives 8 inputs).
DUT_LAT, 0, cycles from a vec_out change until dut_y is valid (0 = combinational circuit).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin a sweep; sampled only in IDLE
vec_out  out  2W  vector driven to the circuit under test; s = vec_out[W-1:0], t = vec_out[2W-1:W]
dut_y  in  1  output of the circuit under test for vec_out
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when the sweep completes
pass  out  1  1 if mismatch_count == 0; valid from done, held until the next start
mismatch_count  out  2W+1  number of vectors where dut_y != IC
first_fail_valid  out  1  at least one mismatch recorded
first_fail_vec  out  2W  lowest vec_out value that mismatched

Behaviour:
- Reset (async, any state, including mid-sweep): state=IDLE; vec_out=0; busy=0; done=0; pass=0; mismatch_count=0; first_fail_valid=0; first_fail_vec=0. All internal counters are cleared.
- State: IDLE
  - start=1 → SEARCH.
  - On the transition: vec=0, x=0, settle=0, hit=0, and all result outputs are cleared.
- State: SEARCH (one x per cycle)
  - Evaluate r = ashr(x, s). For s >= W, r = all bits equal to x[W-1] (saturating shift).
  - r == t → set hit, go to WAIT.
  - Otherwise x == 2^W-1 → hit=0, go to WAIT.
  - Otherwise x++.
- State: WAIT
  - Leave for COMPARE once settle >= DUT_LAT.
  - settle counts cycles since vec_out last changed and saturates at DUT_LAT.
- State: COMPARE (one cycle)
  - Sample dut_y.
  - If dut_y != hit: mismatch_count++.
  - If first_fail_valid=0: first_fail_vec=vec, first_fail_valid=1.
  - Go to NEXT.
- State: NEXT (one cycle)
  - If vec == 2^(2W)-1 → DONE.
  - Otherwise vec++, x=0, settle=0, go to SEARCH. vec_out updates in this cycle.
- State: DONE (one cycle)
  - done=1, busy=0, pass=(mismatch_count==0).
  - Go to IDLE. Results are held.
- vec_out is stable from NEXT until the following NEXT; it never changes during SEARCH, WAIT or COMPARE.
- Timing with DUT_LAT=0: per-vector cycles = (first matching x + 1, or 2^W if none) + 3 (WAIT, COMPARE, NEXT).
- start is ignored while busy. start asserted in the DONE cycle is also ignored.
- mismatch_count cannot overflow: its maximum value is 2^(2W).

Decomposition:
- Package ic_check_pkg holds:
  - the state enum {IDLE, SEARCH, WAIT, COMPARE, NEXT, DONE};
  - function ashr_sat(x, s, W);
  - localparams NVEC = 2^(2W) and NX = 2^W.
- Sub-module bvashr_ref_unit (combinational): inputs x, s, t; output eq = (ashr_sat(x,s) == t). Instantiated once in the SEARCH datapath.

Test Plan (W=4 unless noted):
- Golden behavioural IC model as the circuit under test, DUT_LAT=0, start pulse → done after the full sweep; pass=1, mismatch_count=0, first_fail_valid=0. 54 of the 256 vectors have IC=1.
- dut_y stuck at 0 → mismatch_count=54, first_fail_vec=0x00 (s=0, t=0, reachable), pass=0.
- dut_y stuck at 1 → mismatch_count=202, first_fail_vec=0x13 (s=3, t=0001, unreachable).
- Golden model with its output inverted only at vec 0xA7 (s=7, t=1010, IC=0) → mismatch_count=1, first_fail_vec=0xA7.
- DUT_LAT=3, golden model delayed 3 cycles → pass=1. The same model with DUT_LAT=0 → pass=0.
- Async rst asserted mid-sweep at vec 0x40 → all outputs return to reset values immediately. A new start gives a clean sweep with results identical to the first test.
